// File: rtl/cell_test_sequencer_if.sv
// Wishbone slave-port bundle between the Caravel bus and the cell test sequencer.
// Signal names keep the Caravel port naming so the two sides line up at a glance.
interface cell_test_sequencer_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/cell_test_sequencer.sv
// Exhaustive sweep of one combinational test cell: drives every input vector, waits a
// programmable settle time, and compacts the synchronized response into CRC-32 + ones count.
module cell_test_sequencer #(
    parameter int          N_IN_MAX  = 12,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    cell_test_sequencer_if.slave wbs,
    output logic [N_IN_MAX-1:0]  stim_o,
    input  logic                 resp_i,
    output logic                 busy_o,
    output logic                 irq_o
);
    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, SAMPLE} state_e;

    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [5:0]  N_MAX    = 6'(N_IN_MAX);
    localparam int          ONES_W   = N_IN_MAX + 1;

    state_e                state_q, state_d;
    logic                  ack_q, ack_d;
    logic [31:0]           dat_q, dat_d;
    logic [N_IN_MAX-1:0]   stim_q, stim_d;
    logic [N_IN_MAX-1:0]   vec_q, vec_d;
    logic [ONES_W-1:0]     ones_q, ones_d;
    logic [31:0]           sig_q, sig_d;
    logic [8:0]            cnt_q, cnt_d;
    logic [4:0]            n_in_q, n_in_d;
    logic [7:0]            settle_q, settle_d;
    logic                  irq_en_q, irq_en_d;
    logic                  done_q, done_d;
    logic                  aborted_q, aborted_d;
    logic                  err_q, err_d;
    logic                  resp_s1_q, resp_s1_d;
    logic                  resp_s2_q, resp_s2_d;

    logic                  hit, acc, wr, rd;
    logic [2:0]            idx;
    logic                  start_req, abort_req, clr_req, cfg_ok, vec_last, fb;
    logic [N_IN_MAX-1:0]   span, last_vec;
    logic [31:0]           rdata, sig_shift;
    logic                  unused_bus_bits;

    assign unused_bus_bits = ^{wbs.wbs_sel_i, wbs.wbs_adr_i, wbs.wbs_dat_i};

    // Bus decode, register read mux and sweep helpers.
    always_comb begin
        hit       = wbs.wbs_stb_i & wbs.wbs_cyc_i & (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
        acc       = hit & ~ack_q;
        wr        = acc & wbs.wbs_we_i;
        rd        = acc & ~wbs.wbs_we_i;
        idx       = wbs.wbs_adr_i[4:2];
        start_req = wr && (idx == 3'd0) && wbs.wbs_dat_i[0];
        abort_req = wr && (idx == 3'd0) && wbs.wbs_dat_i[1];
        clr_req   = wr && (idx == 3'd0) && wbs.wbs_dat_i[2];
        cfg_ok    = (n_in_q != 5'd0) && ({1'b0, n_in_q} <= N_MAX);
        // For n_in == N_IN_MAX the shift wraps to 0 and the subtract yields all-ones.
        span      = {{(N_IN_MAX-1){1'b0}}, 1'b1} << n_in_q;
        last_vec  = span - {{(N_IN_MAX-1){1'b0}}, 1'b1};
        vec_last  = (vec_q == last_vec);
        fb        = sig_q[31] ^ resp_s2_q;
        sig_shift = {sig_q[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
        unique case (idx)
            3'd1:    rdata = {15'b0, irq_en_q, settle_q, 3'b0, n_in_q};
            3'd2:    rdata = {28'b0, err_q, aborted_q, done_q, busy_o};
            3'd3:    rdata = 32'(ones_q);
            3'd4:    rdata = sig_q;
            3'd5:    rdata = 32'(vec_q);
            default: rdata = 32'h0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_req && cfg_ok) state_d = DRIVE;
            DRIVE:   state_d = SETTLE;
            SETTLE:  if (cnt_q == 9'd1) state_d = SAMPLE;
            SAMPLE:  state_d = vec_last ? IDLE : DRIVE;
            default: state_d = IDLE;
        endcase
        if (busy_o && abort_req) state_d = IDLE;
    end

    always_comb begin
        busy_o        = (state_q != IDLE);
        irq_o         = done_q & irq_en_q;
        stim_o        = stim_q;
        wbs.wbs_ack_o = ack_q;
        wbs.wbs_dat_o = dat_q;
    end

    always_comb begin
        ack_d     = acc;
        dat_d     = rd ? rdata : 32'h0;
        resp_s1_d = resp_i;
        resp_s2_d = resp_s1_q;
        vec_d     = vec_q;
        ones_d    = ones_q;
        sig_d     = sig_q;
        cnt_d     = cnt_q;
        n_in_d    = n_in_q;
        settle_d  = settle_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        aborted_d = aborted_q;
        err_d     = err_q;

        if (wr && (idx == 3'd1) && !busy_o) begin
            n_in_d   = wbs.wbs_dat_i[4:0];
            settle_d = wbs.wbs_dat_i[15:8];
            irq_en_d = wbs.wbs_dat_i[16];
        end
        if (clr_req) begin
            done_d    = 1'b0;
            aborted_d = 1'b0;
            err_d     = 1'b0;
        end

        // Abort freezes the partial results; nothing else in the sweep advances.
        if (busy_o && abort_req) begin
            aborted_d = 1'b1;
            done_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_req) begin
                        if (cfg_ok) begin
                            vec_d     = '0;
                            ones_d    = '0;
                            sig_d     = 32'hFFFF_FFFF;
                            done_d    = 1'b0;
                            aborted_d = 1'b0;
                            err_d     = 1'b0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                DRIVE:  cnt_d = {1'b0, settle_q} + 9'd2;
                SETTLE: cnt_d = cnt_q - 9'd1;
                SAMPLE: begin
                    sig_d  = sig_shift;
                    ones_d = ones_q + {{N_IN_MAX{1'b0}}, resp_s2_q};
                    if (vec_last) done_d = 1'b1;
                    else          vec_d  = vec_q + {{(N_IN_MAX-1){1'b0}}, 1'b1};
                end
                default: ;
            endcase
        end

        stim_d = stim_q;
        if (state_d == IDLE)       stim_d = '0;
        else if (state_q == DRIVE) stim_d = vec_q;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= IDLE;
            ack_q     <= 1'b0;
            dat_q     <= 32'h0;
            stim_q    <= '0;
            vec_q     <= '0;
            ones_q    <= '0;
            sig_q     <= 32'hFFFF_FFFF;
            cnt_q     <= 9'd0;
            n_in_q    <= 5'd0;
            settle_q  <= 8'd0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
            resp_s1_q <= 1'b0;
            resp_s2_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            stim_q    <= stim_d;
            vec_q     <= vec_d;
            ones_q    <= ones_d;
            sig_q     <= sig_d;
            cnt_q     <= cnt_d;
            n_in_q    <= n_in_d;
            settle_q  <= settle_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            err_q     <= err_d;
            resp_s1_q <= resp_s1_d;
            resp_s2_q <= resp_s2_d;
        end
    end
endmodule
